// File: rtl/sd_mem_port_arb_if.sv
// rtl/sd_mem_port_arb_if.sv - request/grant bundle between FIFO controllers and the memory port arbiter
interface sd_mem_port_arb_if #(
  parameter int ports = 4,
  parameter int asz   = 4,
  parameter int psz   = $clog2(ports)
);
  logic [ports-1:0]     req;
  logic [ports-1:0]     lock;
  logic [ports*asz-1:0] p_addr;
  logic [ports-1:0]     p_we;
  logic [ports-1:0]     enable;
  logic [asz-1:0]       mem_addr;
  logic                 mem_we;
  logic [psz-1:0]       grant_id;
  logic                 rd_valid;
  logic [psz-1:0]       rd_port;

  modport master (
    output req, lock, p_addr, p_we,
    input  enable, mem_addr, mem_we, grant_id, rd_valid, rd_port
  );

  modport slave (
    input  req, lock, p_addr, p_we,
    output enable, mem_addr, mem_we, grant_id, rd_valid, rd_port
  );
endinterface

// File: rtl/sd_mem_port_arb.sv
// rtl/sd_mem_port_arb.sv - round-robin arbiter with bounded lock sharing one single-port memory
module sd_mem_port_arb #(
  parameter int ports    = 4,
  parameter int asz      = 4,
  parameter int max_lock = 4,
  parameter int psz      = $clog2(ports)
) (
  input  logic               clk,
  input  logic               reset_n,
  sd_mem_port_arb_if.slave   bus
);
  localparam int              cw          = $clog2(max_lock + 1);
  localparam logic            ST_UNLOCKED = 1'b0;
  localparam logic            ST_LOCKED   = 1'b1;
  localparam logic [cw-1:0]   LOCK_LAST   = cw'(max_lock - 1);
  localparam logic [psz-1:0]  LAST_RST    = psz'(ports - 1);

  logic [psz-1:0] r_last;
  logic [psz-1:0] r_owner;
  logic           r_locked;
  logic [cw-1:0]  r_lock_cnt;
  logic           r_rd_valid;
  logic [psz-1:0] r_rd_port;

  logic           w_owner_hit;
  logic           w_grant;
  logic           w_we;
  logic [psz-1:0] w_gid;
  logic [psz-1:0] w_idx;
  logic [asz-1:0] w_addr [ports];

  for (genvar i = 0; i < ports; i++) begin : g_addr
    assign w_addr[i] = bus.p_addr[i*asz +: asz];
  end

  assign w_owner_hit = (r_locked == ST_LOCKED) && bus.req[r_owner];

  // A live lock overrides the scan; a dropped lock falls straight through to round-robin.
  always_comb begin
    w_grant = 1'b0;
    w_gid   = '0;
    w_idx   = '0;
    if (w_owner_hit) begin
      w_grant = 1'b1;
      w_gid   = r_owner;
    end else begin
      for (int k = 1; k <= ports; k++) begin
        w_idx = psz'((int'(r_last) + k) % ports);
        if (!w_grant && bus.req[w_idx]) begin
          w_grant = 1'b1;
          w_gid   = w_idx;
        end
      end
    end
  end

  assign w_we         = w_grant & bus.p_we[w_gid];
  assign bus.enable   = w_grant ? (ports'(1) << w_gid) : '0;
  assign bus.mem_addr = w_grant ? w_addr[w_gid] : '0;
  assign bus.mem_we   = w_we;
  assign bus.grant_id = w_gid;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_port  = r_rd_port;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last     <= LAST_RST;
      r_owner    <= '0;
      r_locked   <= ST_UNLOCKED;
      r_lock_cnt <= '0;
      r_rd_valid <= 1'b0;
      r_rd_port  <= '0;
    end else begin
      r_rd_valid <= w_grant & ~w_we;
      if (w_grant && !w_we) begin
        r_rd_port <= w_gid;
      end
      if (w_grant) begin
        r_last <= w_gid;
        if (w_owner_hit) begin
          // Leaving the lock with r_last=owner puts the owner last in line next cycle.
          if (bus.lock[r_owner] && (r_lock_cnt < LOCK_LAST)) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end else begin
            r_locked   <= ST_UNLOCKED;
            r_lock_cnt <= '0;
          end
        end else if (bus.lock[w_gid] && (max_lock > 1)) begin
          r_locked   <= ST_LOCKED;
          r_owner    <= w_gid;
          r_lock_cnt <= cw'(1);
        end else begin
          r_locked   <= ST_UNLOCKED;
          r_lock_cnt <= '0;
        end
      end else begin
        r_locked   <= ST_UNLOCKED;
        r_lock_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sd_mem_port_arb.sv
// tb/tb_sd_mem_port_arb.sv - scoreboard bench for the memory port arbiter
module tb_sd_mem_port_arb;
  typedef struct packed {
    logic [3:0] en;
    logic [3:0] addr;
    logic       we;
    logic [1:0] gid;
  } comb_t;

  typedef struct packed {
    logic       v;
    logic [1:0] p;
  } rd_t;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [3:0]  p_we;
  logic [15:0] p_addr;

  comb_t q_comb[$];
  rd_t   q_rd[$];
  logic [1:0] model_rd_p;
  int n_checks;
  int n_fail;

  sd_mem_port_arb_if #(.ports(4), .asz(4)) bus ();

  assign bus.req    = req;
  assign bus.lock   = lock;
  assign bus.p_we   = p_we;
  assign bus.p_addr = p_addr;

  sd_mem_port_arb #(.ports(4), .asz(4), .max_lock(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic sb_clear();
    q_comb.delete();
    q_rd.delete();
    model_rd_p = 2'd0;
    q_rd.push_back(rd_t'(3'b000));
  endtask

  // Drive one cycle; exp_en is the grant this bench expects for the stimulus.
  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] l,
                      input logic [3:0] w, input logic [3:0] exp_en);
    comb_t e;
    comb_t g;
    rd_t   n;
    rd_t   c;
    int    gid;
    gid = 0;
    for (int i = 0; i < 4; i++) if (exp_en[i]) gid = i;
    e.en   = exp_en;
    e.gid  = gid[1:0];
    e.addr = (exp_en != 4'd0) ? p_addr[gid*4 +: 4] : 4'd0;
    e.we   = (exp_en != 4'd0) && w[gid];
    req  = r;
    lock = l;
    p_we = w;
    q_comb.push_back(e);
    n.v = (exp_en != 4'd0) && !e.we;
    if (n.v) model_rd_p = gid[1:0];
    n.p = model_rd_p;
    q_rd.push_back(n);
    @(negedge clk);
    g = q_comb.pop_front();
    c = q_rd.pop_front();
    check({tag, ".enable"},   32'(bus.enable),   32'(g.en));
    check({tag, ".grant_id"}, 32'(bus.grant_id), 32'(g.gid));
    check({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(g.addr));
    check({tag, ".mem_we"},   32'(bus.mem_we),   32'(g.we));
    check({tag, ".onehot"},   32'($countones(bus.enable) <= 1), 32'(1));
    check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(c.v));
    check({tag, ".rd_port"},  32'(bus.rd_port),  32'(c.p));
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    req      = 4'd0;
    lock     = 4'd0;
    p_we     = 4'd0;
    p_addr   = {4'h3, 4'hA, 4'h7, 4'h1};
    sb_clear();

    #1;
    check("rst.enable",   32'(bus.enable),   32'(0));
    check("rst.mem_addr", 32'(bus.mem_addr), 32'(0));
    check("rst.mem_we",   32'(bus.mem_we),   32'(0));
    check("rst.grant_id", 32'(bus.grant_id), 32'(0));
    check("rst.rd_valid", 32'(bus.rd_valid), 32'(0));
    check("rst.rd_port",  32'(bus.rd_port),  32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    step("rr0", 4'b1111, 4'b0000, 4'b0000, 4'b0001);
    step("rr1", 4'b1111, 4'b0000, 4'b0000, 4'b0010);
    step("rr2", 4'b1111, 4'b0000, 4'b0000, 4'b0100);
    step("rr3", 4'b1111, 4'b0000, 4'b0000, 4'b1000);
    step("rr4", 4'b1111, 4'b0000, 4'b0000, 4'b0001);
    step("rr5", 4'b1111, 4'b0000, 4'b0000, 4'b0010);

    step("wr2",   4'b0100, 4'b0000, 4'b0100, 4'b0100);
    step("wr2nx", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    step("rd1",  4'b0010, 4'b0000, 4'b0000, 4'b0010);
    step("rd3",  4'b1000, 4'b0000, 4'b0000, 4'b1000);
    step("rdnx", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    for (int i = 0; i < 10; i++) begin
      step($sformatf("lk%0d", i), 4'b0011, 4'b0001, 4'b0000,
           ((i % 5) == 4) ? 4'b0010 : 4'b0001);
    end
    step("lkidle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    step("drop_a", 4'b0100, 4'b0100, 4'b0000, 4'b0100);
    step("drop_b", 4'b0100, 4'b0100, 4'b0000, 4'b0100);
    step("drop_c", 4'b1001, 4'b0000, 4'b0000, 4'b1000);
    step("drop_d", 4'b0101, 4'b0000, 4'b0000, 4'b0001);

    step("mid_a", 4'b1111, 4'b0010, 4'b0000, 4'b0010);
    step("mid_b", 4'b1111, 4'b0010, 4'b0000, 4'b0010);
    req     = 4'b1111;
    lock    = 4'b0000;
    reset_n = 1'b0;
    #1;
    check("mid_rst.enable",   32'(bus.enable),   32'(4'b0001));
    check("mid_rst.grant_id", 32'(bus.grant_id), 32'(0));
    check("mid_rst.mem_addr", 32'(bus.mem_addr), 32'(4'h1));
    check("mid_rst.rd_valid", 32'(bus.rd_valid), 32'(0));
    check("mid_rst.rd_port",  32'(bus.rd_port),  32'(0));
    req = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;
    sb_clear();
    @(posedge clk);
    #1;
    step("post0", 4'b1111, 4'b0000, 4'b0000, 4'b0001);
    step("post1", 4'b1111, 4'b0000, 4'b0000, 4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
